// File: rtl/tnet_tx_initiator.sv
// rtl/tnet_tx_initiator.sv - tnet transmit initiator: command FIFO, packet packing, 4-phase req/ack
// Commands are queued, packed into 128-bit packets and offered one at a time to the link controller.
module tnet_tx_initiator #(
  parameter int FIFO_AW = 3,
  parameter int TMO_CYC = 1024
) (
  input  logic                 t_clk_i,
  input  logic                 t_rst_i,
  input  logic [7:0]           id_i,
  input  logic                 cmd_vld_i,
  output logic                 cmd_rdy_o,
  input  logic [7:0]           cmd_op_i,
  input  logic                 cmd_sync_i,
  input  logic [8:0]           cmd_dst_i,
  input  logic [95:0]          cmd_dt_i,
  output logic                 tx_req_o,
  output logic [127:0]         tx_dt_o,
  input  logic                 tx_ack_i,
  output logic                 busy_o,
  output logic [FIFO_AW:0]     fifo_cnt_o,
  output logic [31:0]          tx_cnt_o,
  output logic                 err_ovf_o,
  output logic                 err_tmo_o,
  input  logic                 clr_err_i
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMO_MAX = TW'(TMO_CYC);
  localparam logic [TW-1:0] TMO_HIT = TW'(TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_NACK} state_t;

  state_t               state_q, state_d;
  logic [113:0]         mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     cnt;
  logic [113:0]         head;
  logic                 full, empty, push, pop;
  logic                 ack_s1, ack_s;
  logic [TW-1:0]        tmo_cnt;
  logic                 in_req_wait;

  assign full        = (cnt == FULL_CNT);
  assign empty       = (cnt == '0);
  assign push        = cmd_vld_i & ~full;
  assign head        = mem[rd_ptr];
  assign cmd_rdy_o   = ~full;
  assign fifo_cnt_o  = cnt;
  assign busy_o      = (state_q != IDLE) | ~empty;
  assign in_req_wait = (state_q == REQ) & ~ack_s;

  always_ff @(posedge t_clk_i) begin
    if (push) mem[wr_ptr] <= {cmd_op_i, cmd_sync_i, cmd_dst_i, cmd_dt_i};
  end

  always_ff @(posedge t_clk_i) begin
    if (t_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ack_s1 <= 1'b0;
      ack_s  <= 1'b0;
    end else begin
      ack_s1 <= tx_ack_i;
      ack_s  <= ack_s1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A new request is only raised once the previous ack has been seen low.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !ack_s) begin
          pop     = 1'b1;
          state_d = REQ;
        end
      end
      REQ:       if (ack_s)  state_d = WAIT_NACK;
      WAIT_NACK: if (!ack_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge t_clk_i) begin
    if (t_rst_i) begin
      state_q   <= IDLE;
      tx_req_o  <= 1'b0;
      tx_dt_o   <= '0;
      tx_cnt_o  <= '0;
      tmo_cnt   <= '0;
      err_ovf_o <= 1'b0;
      err_tmo_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_req_o <= (state_d == REQ);
      if (pop)
        tx_dt_o <= {head[113:106], head[105], 5'b0, head[104:96], 1'b0, id_i, head[95:0]};
      if ((state_q == REQ) && ack_s) tx_cnt_o <= tx_cnt_o + 32'd1;
      if (pop)
        tmo_cnt <= '0;
      else if (in_req_wait && (tmo_cnt != TMO_MAX))
        tmo_cnt <= tmo_cnt + 1'b1;
      // Sticky errors: a set in the same cycle as clear takes priority.
      if (cmd_vld_i && full)    err_ovf_o <= 1'b1;
      else if (clr_err_i)       err_ovf_o <= 1'b0;
      if (in_req_wait && (tmo_cnt == TMO_HIT)) err_tmo_o <= 1'b1;
      else if (clr_err_i)       err_tmo_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tnet_tx_initiator.sv
// tb/tb_tnet_tx_initiator.sv - randomized self-checking bench for tnet_tx_initiator
// A queue of pushed commands is the reference; packets are built from the field map at handshake time.
module tb_tnet_tx_initiator;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int TMO = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    id;
  logic          cmd_vld, cmd_rdy, cmd_sync;
  logic [7:0]    cmd_op;
  logic [8:0]    cmd_dst;
  logic [95:0]   cmd_dt;
  logic          tx_req, tx_ack, busy, err_ovf, err_tmo, clr_err;
  logic [127:0]  tx_dt;
  logic [AW:0]   fifo_cnt;
  logic [31:0]   tx_cnt;

  always #5 clk = ~clk;

  tnet_tx_initiator #(.FIFO_AW(AW), .TMO_CYC(TMO)) dut (
    .t_clk_i(clk), .t_rst_i(rst), .id_i(id),
    .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy), .cmd_op_i(cmd_op), .cmd_sync_i(cmd_sync),
    .cmd_dst_i(cmd_dst), .cmd_dt_i(cmd_dt),
    .tx_req_o(tx_req), .tx_dt_o(tx_dt), .tx_ack_i(tx_ack),
    .busy_o(busy), .fifo_cnt_o(fifo_cnt), .tx_cnt_o(tx_cnt),
    .err_ovf_o(err_ovf), .err_tmo_o(err_tmo), .clr_err_i(clr_err)
  );

  typedef struct packed {
    logic [7:0]  op;
    logic        sync;
    logic [8:0]  dst;
    logic [95:0] dt;
  } cmd_t;

  cmd_t         exp_q[$];
  int           occ = 0;
  int           exp_tx = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [127:0] last_dt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input cmd_t c, input logic [7:0] node);
    logic [127:0] p;
    p = '0;
    p[127:120] = c.op;
    p[119]     = c.sync;
    p[113:105] = c.dst;
    p[103:96]  = node;
    p[95:0]    = c.dt;
    return p;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op   = 8'($urandom);
    c.sync = 1'($urandom);
    c.dst  = 9'($urandom);
    c.dt   = {$urandom, $urandom, $urandom};
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input cmd_t c);
    cmd_op = c.op; cmd_sync = c.sync; cmd_dst = c.dst; cmd_dt = c.dt;
    cmd_vld = 1'b1;
    if (occ < DEPTH) begin
      exp_q.push_back(c);
      occ++;
    end
    tick(1);
    cmd_vld = 1'b0;
  endtask

  task automatic take(input string tag);
    int k;
    cmd_t c;
    k = 0;
    while (!tx_req && k < 40) begin
      tick(1);
      k++;
    end
    check({tag, "_req_rise"}, tx_req, 1'b1);
    occ--;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_pkt"}, 1'b1, 1'b0);
      c = '0;
    end else begin
      c = exp_q.pop_front();
    end
    check({tag, "_pkt"}, tx_dt, pack(c, id));
    last_dt = tx_dt;
  endtask

  task automatic finish(input string tag, input int delay);
    int k;
    tick(delay);
    tx_ack = 1'b1;
    k = 0;
    while (tx_req && k < 10) begin
      tick(1);
      k++;
    end
    check({tag, "_req_fall"}, tx_req, 1'b0);
    check({tag, "_dt_held"}, tx_dt, last_dt);
    exp_tx++;
    check({tag, "_tx_cnt"}, tx_cnt, exp_tx);
    tx_ack = 1'b0;
    tick(2);
    check({tag, "_no_req_under_ack"}, tx_req, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cmd_t c;
    int n, seen;
    rst = 1'b1; id = 8'h07; cmd_vld = 1'b0; cmd_op = '0; cmd_sync = 1'b0;
    cmd_dst = '0; cmd_dt = '0; tx_ack = 1'b0; clr_err = 1'b0;
    tick(2);
    check("rst_req", tx_req, 1'b0);
    check("rst_dt", tx_dt, 128'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_cnt", fifo_cnt, 0);
    check("rst_tx_cnt", tx_cnt, 0);
    check("rst_errs", {err_ovf, err_tmo}, 2'b00);
    check("rst_rdy", cmd_rdy, 1'b1);
    rst = 1'b0;
    tick(1);

    // single push: request must rise on the second edge after the push is sampled
    c.op = 8'hA5; c.sync = 1'b0; c.dst = 9'h003; c.dt = 96'h1234;
    push(c);
    check("lat_edge1", tx_req, 1'b0);
    tick(1);
    check("lat_edge2", tx_req, 1'b1);
    check("single_literal", tx_dt, 128'hA5000607_00000000_00000000_00001234);
    take("single");
    finish("single", 2);
    tick(4);

    c.op = 8'h3C; c.sync = 1'b1; c.dst = 9'h1FF; c.dt = {$urandom, $urandom, $urandom};
    push(c);
    take("bcast");
    check("bcast_sync", tx_dt[119], 1'b1);
    check("bcast_dst", tx_dt[113:105], 9'h1FF);
    finish("bcast", 1);
    tick(4);

    push(rand_cmd());
    take("tmo");
    tick(TMO - 2);
    check("tmo_early", err_tmo, 1'b0);
    tick(4);
    check("tmo_set", err_tmo, 1'b1);
    check("tmo_req_held", tx_req, 1'b1);
    finish("tmo", 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("tmo_clr", err_tmo, 1'b0);
    tick(4);

    // burst with ack held high in IDLE: nothing may be popped, ninth push overflows
    tx_ack = 1'b1;
    tick(3);
    for (int i = 0; i < 9; i++) push(rand_cmd());
    check("burst_cnt", fifo_cnt, DEPTH);
    check("burst_rdy", cmd_rdy, 1'b0);
    check("burst_ovf", err_ovf, 1'b1);
    check("burst_no_req", tx_req, 1'b0);
    check("burst_busy", busy, 1'b1);
    clr_err = 1'b1;
    push(rand_cmd());
    clr_err = 1'b0;
    check("ovf_set_wins", err_ovf, 1'b1);
    check("ovf_cnt_stuck", fifo_cnt, DEPTH);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ovf_clr", err_ovf, 1'b0);
    tx_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      take("burst");
      finish("burst", int'($urandom_range(0, 3)));
    end
    tick(4);
    check("burst_drained", fifo_cnt, 0);

    for (int r = 0; r < 4; r++) begin
      tx_ack = 1'b1;
      tick(3);
      id = 8'($urandom);
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) push(rand_cmd());
      check("rnd_cnt", fifo_cnt, n);
      id = 8'($urandom);
      tx_ack = 1'b0;
      for (int i = 0; i < n; i++) begin
        take("rnd");
        finish("rnd", int'($urandom_range(0, 5)));
      end
      tick(4);
      check("rnd_idle", busy, 1'b0);
    end

    // reset in the middle of a handshake with three commands queued
    push(rand_cmd());
    take("rst_mid");
    for (int i = 0; i < 3; i++) push(rand_cmd());
    check("rst_mid_cnt", fifo_cnt, 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_req", tx_req, 1'b0);
    check("rst_mid_fifo", fifo_cnt, 0);
    check("rst_mid_tx_cnt", tx_cnt, 0);
    exp_q.delete();
    occ = 0;
    exp_tx = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (tx_req) seen = 1;
    end
    check("rst_mid_no_pkt", seen, 0);
    check("rst_mid_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
